corr_rect_multi: RTL and testbench
==================================

CORR_RECT_MULTI -- requirements
Module: corr_rect_multi

Interface
REQ-001 SHALL have parameter N_PAIRS, default 4: number of independent (x,y) channel pairs, legal 1..8.
REQ-002 SHALL have parameter MAX_WINDOW_LENGTH_EXP, default 16: counter width CW in bits, legal 8..24.
REQ-003 SHALL have parameter REPORT_BYTES, default 1: bytes reported per counter, MSB-first, legal 1..3, with 8*REPORT_BYTES <= CW.
REQ-004 SHALL have one clock and a synchronous, active-high reset: i_clk  input  1  rising-edge clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_cg  input  1  clock gate; when low, all state holds.
REQ-007 i_strobe  input  1  sample strobe; one sample is taken per cycle with i_cg && i_strobe.
REQ-008 i_x  input  N_PAIRS  x bit per pair.
REQ-009 i_y  input  N_PAIRS  y bit per pair.
REQ-010 i_windowLengthExp  input  $clog2(CW+1)  window of 2^exp samples; values above CW clamp to CW.
REQ-011 o_data  output  8  packet byte.
REQ-012 o_valid  output  1  o_data is valid.
REQ-013 i_ready  input  1  consumer accepts the byte when o_valid && i_ready.
REQ-014 o_winNum  output  8  count of windows ended, wrapping.
REQ-015 o_nDropped  output  7  count of dropped packets, saturating at 127.

Function
REQ-016 Per pair, on each sample SHALL increment countX if x, countY if y, countIsect if x&y, countSymdiff if x^y; every counter SHALL saturate at 2^CW-1.
REQ-017 A CW-bit sample counter t SHALL increment per sample; window end = sample taken with t[exp-1:0] all ones (exp=0: every sample).
REQ-018 At window end SHALL zero t and all counts next cycle; the snapshot SHALL include the current sample's contribution.
REQ-019 A change of the clamped i_windowLengthExp (registered compare) SHALL zero t and counts without a window end or packet.
REQ-020 At every window end o_winNum SHALL increment, whether the packet is queued or dropped.
REQ-021 FSM SHALL have two states: IDLE (o_valid=0) and EMIT; byte index counter spans 0..L-1 with L = 2+4*N_PAIRS*REPORT_BYTES.
REQ-022 IDLE->EMIT on window end: snapshot counts into the packet buffer, latch header, index=0.
REQ-023 Packet byte 0 SHALL be winNum after increment; byte 1 SHALL be {overflowSticky, o_nDropped}.
REQ-024 Bytes 2.. SHALL be, for pair 0..N-1, X,Y,Isect,Symdiff, each counter[CW-1 -: 8*REPORT_BYTES] MSB byte first.
REQ-025 o_data/o_valid SHALL stay stable while o_valid && !i_ready; index advances only on acceptance.
REQ-026 EMIT->IDLE on acceptance of byte L-1; overflowSticky SHALL clear when byte 1 is accepted.
REQ-027 A window end in EMIT SHALL drop the new snapshot, set overflowSticky, and increment o_nDropped (saturating), unless it coincides with acceptance of byte L-1, in which case the new packet loads (EMIT->EMIT, index=0).
REQ-028 o_nDropped SHALL never reset except by i_rst.
REQ-029 Window-end-to-o_valid latency SHALL be 1 cycle.

Reset
REQ-030 i_rst SHALL set state IDLE, o_valid=0, o_data=0, o_winNum=0, o_nDropped=0, overflowSticky=0, t=0, all counts=0; i_rst overrides i_cg.
REQ-031 Reset mid-packet SHALL abandon the packet; no partial bytes are emitted afterwards.

Structure
REQ-032 Shared package corr_pkg SHALL hold the FSM state encoding, header byte offsets (HDR_WINNUM=0, HDR_FLAGS=1), and the packet-length function.
REQ-033 Per-pair counting SHALL be one sub-module corr_pair_count, instantiated N_PAIRS times.

Verification
REQ-034 N=1, CW=8, exp=2, i_ready=1, x=y=1 every cycle -> packet {0x01,0x00,0x04,0x04,0x04,0x00} every 4 strobes.
REQ-035 N=2, exp=3, pair0 x=1,y=0, pair1 x^y alternating -> Symdiff0=8, Isect0=0; pair1 counts match the model.
REQ-036 i_ready=0 for 3 windows, exp=0 -> first packet held stable; o_nDropped=2; resumed packet flags byte=0x82; the next packet's flags=0x02.
REQ-037 exp=CW=8, x=y=1 for 256 samples -> counts saturate at 0xFF, with no wrap to 0.
REQ-038 Window end coincident with acceptance of the last byte -> back-to-back packets, o_nDropped unchanged.
REQ-039 Change exp mid-window, and assert i_rst mid-packet -> counts zeroed, no packet, o_valid=0 next cycle.

Source files
------------

// File: rtl/corr_pkg.sv
// corr_pkg: shared FSM encoding, header byte layout and packet sizing for corr_rect_multi
package corr_pkg;
  typedef enum logic {IDLE, EMIT} state_t;
  localparam int HDR_WINNUM = 0;
  localparam int HDR_FLAGS = 1;
  function automatic int pkt_len(input int n_pairs, input int report_bytes);
    return 2 + 4 * n_pairs * report_bytes;
  endfunction
endpackage

// File: rtl/corr_pair_count.sv
// corr_pair_count: saturating x/y/intersection/symmetric-difference counters for one channel pair
module corr_pair_count #(
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 x,
  input  logic                 y,
  output logic [3:0][CW-1:0]   nxt
);
  logic [3:0][CW-1:0] cnt;
  logic [3:0] hit;
  assign hit = {x ^ y, x & y, y, x};
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    assign nxt[k] = (en && hit[k] && !(&cnt[k])) ? cnt[k] + 1'b1 : cnt[k];
  end
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= nxt;
  end
endmodule

// File: rtl/corr_rect_multi.sv
// corr_rect_multi: windowed per-pair correlation counters streamed out as byte packets
module corr_rect_multi
  import corr_pkg::*;
#(
  parameter int N_PAIRS = 4,
  parameter int MAX_WINDOW_LENGTH_EXP = 16,
  parameter int REPORT_BYTES = 1,
  localparam int CW = MAX_WINDOW_LENGTH_EXP,
  localparam int EW = $clog2(CW + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  input  logic               i_strobe,
  input  logic [N_PAIRS-1:0] i_x,
  input  logic [N_PAIRS-1:0] i_y,
  input  logic [EW-1:0]      i_windowLengthExp,
  output logic [7:0]         o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [7:0]         o_winNum,
  output logic [6:0]         o_nDropped
);
  localparam int RW = 8 * REPORT_BYTES;
  localparam int NB = 4 * N_PAIRS * REPORT_BYTES;
  localparam int L = pkt_len(N_PAIRS, REPORT_BYTES);
  localparam int IW = $clog2(L);
  state_t state;
  logic [IW-1:0] idx;
  logic ovf;
  logic [8*NB-1:0] sh, payload;
  logic [N_PAIRS-1:0][3:0][CW-1:0] nxt;
  logic [CW-1:0] t, mask;
  logic [EW-1:0] exp_c, exp_q;
  logic restart, sample, win_end, clr, accept, last;
  assign exp_c = (i_windowLengthExp > EW'(CW)) ? EW'(CW) : i_windowLengthExp;
  assign restart = i_cg && (exp_c != exp_q);
  assign sample = i_cg && i_strobe && !restart;
  assign mask = ~({CW{1'b1}} << exp_q);
  assign win_end = sample && ((t & mask) == mask);
  assign clr = restart || win_end;
  assign o_valid = (state == EMIT);
  assign accept = i_cg && o_valid && i_ready;
  assign last = (idx == IW'(L - 1));
  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    corr_pair_count #(.CW(CW)) u_cnt (
      .clk(i_clk), .rst(i_rst), .clr(clr), .en(sample),
      .x(i_x[p]), .y(i_y[p]), .nxt(nxt[p])
    );
    for (genvar k = 0; k < 4; k++) begin : g_fld
      assign payload[8*NB-1-RW*(4*p+k) -: RW] = nxt[p][k][CW-1 -: RW];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t <= '0;
      exp_q <= exp_c;
    end else if (restart) begin
      t <= '0;
      exp_q <= exp_c;
    end else if (win_end) t <= '0;
    else if (sample) t <= t + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx <= '0;
      o_data <= '0;
      o_winNum <= '0;
      o_nDropped <= '0;
      ovf <= 1'b0;
      sh <= '0;
    end else begin
      if (win_end) o_winNum <= o_winNum + 8'd1;
      if (accept) begin
        idx <= idx + 1'b1;
        o_data <= (idx == IW'(HDR_WINNUM)) ? {ovf, o_nDropped} : sh[8*NB-1 -: 8];
        if (idx != IW'(HDR_WINNUM)) sh <= sh << 8;
        if (idx == IW'(HDR_FLAGS)) ovf <= 1'b0;
        if (last) begin
          state <= IDLE;
          o_data <= '0;
        end
      end
      if (win_end && (state == IDLE || (accept && last))) begin
        state <= EMIT;
        idx <= '0;
        o_data <= o_winNum + 8'd1;
        sh <= payload;
      end else if (win_end) begin
        ovf <= 1'b1;
        if (o_nDropped != 7'h7f) o_nDropped <= o_nDropped + 7'd1;
      end
    end
  end
endmodule

// File: tb/tb_corr_rect_multi.sv
// tb_corr_rect_multi: directed and randomized checks of corr_rect_multi against a sample-level packet model
module tb_corr_rect_multi;
  localparam int NP = 2;
  localparam int CW = 8;
  localparam int RB = 1;
  localparam int L = 2 + 4 * NP * RB;
  localparam int EW = $clog2(CW + 1);
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cg = 1'b1;
  logic strobe = 1'b0;
  logic ready = 1'b0;
  logic [NP-1:0] x = '0;
  logic [NP-1:0] y = '0;
  logic [EW-1:0] wexp = '0;
  logic [7:0] data, win_num;
  logic valid;
  logic [6:0] n_dropped;
  int vectors = 0;
  int errors = 0;
  int cnt [NP][4];
  int pkt [L];
  int nsamp, m_win, m_nd, m_exp, pos, nd0, re;
  bit sticky, busy;
  always #5 clk = ~clk;
  corr_rect_multi #(.N_PAIRS(NP), .MAX_WINDOW_LENGTH_EXP(CW), .REPORT_BYTES(RB)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_strobe(strobe), .i_x(x), .i_y(y),
    .i_windowLengthExp(wexp), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_winNum(win_num), .o_nDropped(n_dropped)
  );
  function automatic int clampe(input int e);
    return (e > CW) ? CW : e;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask
  task automatic clear_counts();
    for (int p = 0; p < NP; p++) for (int k = 0; k < 4; k++) cnt[p][k] = 0;
    nsamp = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1; cg = 1'b1; strobe = 1'b0; ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    m_win = 0; m_nd = 0; sticky = 0; busy = 0; pos = 0;
    m_exp = clampe(int'(wexp));
  endtask
  task automatic cyc(input logic [NP-1:0] xv, input logic [NP-1:0] yv, input logic st,
                     input logic rd, input logic c, input int ev);
    int e;
    bit h [4];
    x = xv; y = yv; strobe = st; ready = rd; cg = c; wexp = EW'(ev);
    check("valid", valid, busy);
    if (busy) check("data", data, pkt[pos]);
    else check("idle_data", data, 0);
    check("winNum", win_num, m_win);
    check("nDropped", n_dropped, m_nd);
    if (c) begin
      if (busy && rd) begin
        if (pos == 0) pkt[1] = (sticky ? 128 : 0) + m_nd;
        if (pos == 1) sticky = 0;
        pos++;
        if (pos == L) busy = 0;
      end
      e = clampe(ev);
      if (e != m_exp) begin
        m_exp = e;
        clear_counts();
      end else if (st) begin
        for (int p = 0; p < NP; p++) begin
          h[0] = xv[p]; h[1] = yv[p]; h[2] = xv[p] & yv[p]; h[3] = xv[p] ^ yv[p];
          for (int k = 0; k < 4; k++) if (h[k] && cnt[p][k] < SAT) cnt[p][k]++;
        end
        nsamp++;
        if (nsamp == (1 << m_exp)) begin
          m_win = (m_win + 1) % 256;
          if (!busy) begin
            busy = 1; pos = 0; pkt[0] = m_win;
            for (int p = 0; p < NP; p++) for (int k = 0; k < 4; k++) pkt[2+4*p+k] = cnt[p][k] >> (CW - 8 * RB);
          end else begin
            sticky = 1;
            if (m_nd < 127) m_nd++;
          end
          clear_counts();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain(input int ev);
    for (int i = 0; i < 3 * L; i++) cyc('0, '0, 1'b0, 1'b1, 1'b1, ev);
  endtask
  initial begin
    wexp = 2;
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_winNum", win_num, 0);
    check("rst_nDropped", n_dropped, 0);
    for (int i = 0; i < 4; i++) cyc('1, '1, 1'b1, 1'b1, 1'b1, 2);
    check("first_byte0", data, 8'h01);
    drain(2);
    for (int i = 0; i < 30; i++) cyc('1, '1, 1'b1, 1'($urandom_range(1, 0)), 1'b1, 2);
    drain(2);
    cyc('0, '0, 1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 8; i++) begin
      logic r;
      r = 1'($urandom);
      cyc({r, 1'b1}, {r ^ i[0], 1'b0}, 1'b1, 1'b1, 1'b1, 3);
    end
    drain(3);
    for (int i = 0; i < 5; i++) cyc(NP'($urandom), NP'($urandom), 1'b1, 1'b1, 1'b1, 3);
    cyc('1, '1, 1'b1, 1'b1, 1'b1, 4);
    check("expchg_valid", valid, 0);
    for (int i = 0; i < 16; i++) cyc(NP'($urandom), NP'($urandom), 1'b1, 1'b1, 1'b1, 4);
    drain(4);
    cyc('0, '0, 1'b0, 1'b1, 1'b1, 12);
    for (int i = 0; i < 128; i++) cyc('1, '1, 1'b1, 1'b1, 1'b1, 12);
    for (int i = 0; i < 128; i++) cyc('1, '1, 1'b1, 1'b1, 1'b1, 8);
    check("sat_byte0", data, m_win);
    drain(8);
    wexp = 0;
    do_reset();
    for (int i = 0; i < 3; i++) cyc('1, '0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0, 1'b0, 1'b1, 0);
    check("drop_count", n_dropped, 2);
    cyc('0, '0, 1'b0, 1'b1, 1'b1, 0);
    check("held_flags", data, 8'h82);
    drain(0);
    cyc('1, '1, 1'b1, 1'b1, 1'b1, 0);
    cyc('0, '0, 1'b0, 1'b1, 1'b1, 0);
    check("next_flags", data, 8'h02);
    drain(0);
    cyc('1, '0, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 2 * L && !(busy && pos == L - 1); i++) cyc('0, '0, 1'b0, 1'b1, 1'b1, 0);
    nd0 = m_nd;
    cyc('0, '1, 1'b1, 1'b1, 1'b1, 0);
    check("b2b_valid", valid, 1);
    check("b2b_byte0", data, m_win);
    check("b2b_nDropped", n_dropped, nd0);
    drain(0);
    cyc('1, '1, 1'b1, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) cyc('0, '0, 1'b0, 1'b1, 1'b1, 0);
    do_reset();
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_winNum", win_num, 0);
    for (int i = 0; i < L + 2; i++) cyc('0, '0, 1'b0, 1'b1, 1'b1, 0);
    re = 3;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 0) re = 3 + (i / 200) % 3;
      cyc(NP'($urandom), NP'($urandom), $urandom_range(3, 0) != 0,
          $urandom_range(3, 0) != 0, $urandom_range(7, 0) != 0, re);
    end
    drain(re);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
